serial_byte_rx: RTL and testbench
=================================

// Module: serial_byte_rx
// PURPOSE
//  Serial-to-parallel receiver for 8-bit frames. The line idles high. Each frame is a
//  start bit (0), 8 data bits LSB-first, then a stop bit (1). Each bit lasts CLKS_PER_BIT clocks.
//  Sits at the receive end of the shift-right serial link. Presents each byte on a
//  valid/ready parallel interface and flags framing and overrun errors.
// PARAMETERS
//  CLKS_PER_BIT  16  clocks per serial bit; even, >= 4
//  DATA_BITS     8   payload bits per frame; fixed at 8 in this revision
// PORTS
//  clock       in   1  single clock; all state updates on posedge clock
//  reset       in   1  asynchronous, active-high; clears all state immediately
//  SerialIn    in   1  asynchronous serial line; idle = 1
//  Data_OUT    out  8  received byte; stable while DataValid = 1
//  DataValid   out  1  byte available; held until consumed
//  DataReady   in   1  consumer accepts; transfer when DataValid & DataReady at posedge
//  FrameError  out  1  one-cycle pulse: stop bit sampled 0
//  Overrun     out  1  one-cycle pulse: byte completed while previous byte unconsumed
// BEHAVIOUR
//  Reset values: Data_OUT=8'h00, DataValid=0, FrameError=0, Overrun=0, state=IDLE,
//   sync flops=1, bit counter=0, shift register=0.
//  SerialIn passes through a 2-flop synchroniser (rx_s). All decisions below use rx_s.
//  FSM states:
//   IDLE:  clear the clock counter; on rx_s=0 go to START.
//   START: count CLKS_PER_BIT/2 clocks (mid-bit). If rx_s=0 there, clear the counter
//          and go to DATA. If rx_s=1, treat it as a glitch and return to IDLE with no output.
//   DATA:  every CLKS_PER_BIT clocks, sample rx_s: sr <= {rx_s, sr[7:1]}.
//          After the 8th sample, go to STOP.
//   STOP:  after CLKS_PER_BIT clocks, sample rx_s.
//          If 1: deliver the byte and go to IDLE.
//          If 0: pulse FrameError, discard the byte, go to BREAK.
//   BREAK: wait for rx_s=1, then go to IDLE. This avoids re-triggering on a held-low line.
//  Delivery (the clock after the stop-bit sample):
//   If DataValid=0, or DataValid=1 with DataReady=1 on that cycle:
//     Data_OUT<=sr and DataValid<=1.
//   Else: keep the old Data_OUT, drop the new byte, pulse Overrun. DataValid stays 1.
//  Consume: DataValid & DataReady at posedge with no delivery that cycle -> DataValid<=0.
//   Data_OUT keeps its last value after it is consumed.
//  DataReady while DataValid=0 has no effect.
//  A new start bit is accepted on the clock after the stop-bit sample (back-to-back frames).
//  Latency: DataValid rises 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clocks after the
//   SerialIn falling edge, within +/-1 clock of synchroniser alignment.
//  reset mid-frame: the partial frame is lost. After reset release the block is in IDLE
//   and waits for a fresh falling edge. It never delivers the partial byte.
//  The clock counter width is $clog2(CLKS_PER_BIT). The counter wraps to 0 at each sample
//   point. The bit index is 3 bits and counts 0..7.
// STRUCTURE
//  Shared package serial_pkg:
//   - rx_state_t enum {IDLE, START, DATA, STOP, BREAK}
//   - DATA_BITS=8; IDLE_LEVEL=1'b1
//   The transmit side shares these constants.
//  One sub-module, sync_2ff (clock, reset, d, q; reset value parameterised, here 1).
//  It is reused for all async inputs.
//  The FSM, counters, shift register and output register live in serial_byte_rx.
// TESTING (CLKS_PER_BIT=4, DataReady=1 unless stated)
//  1. Frame 0xA5 (0,1,0,1,0,0,1,0,1,1) -> DataValid high 1 clk, Data_OUT=8'hA5,
//     no FrameError or Overrun.
//  2. Two back-to-back frames 0x3C, 0xFF with DataReady=0 -> Data_OUT=8'h3C, DataValid stays 1,
//     Overrun pulses once at 2nd delivery. Raising DataReady then clears DataValid.
//  3. Frame 0x55 with stop bit 0, line held low 20 clks -> FrameError 1-clk pulse,
//     DataValid stays 0, no new frame until line returns high.
//  4. 1-clk low glitch on idle line -> START aborts at mid-bit, no output, FSM back in IDLE.
//  5. Assert reset during data bit 4 of 0x81, release, send 0x42 -> only 8'h42 delivered.
//     All outputs at reset values while reset=1.
//  6. DataReady high on the same cycle a new byte (0x99) is delivered over an unconsumed 0x11
//     -> Data_OUT=8'h99, DataValid stays 1, Overrun=0.

Source files
------------

// File: rtl/serial_pkg.sv
// Constants and state type shared by the receive and transmit sides of the serial link.
package serial_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous single-bit inputs; reset level is a parameter.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Metastability chain: d -> meta_r -> sync_r
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/serial_byte_rx.sv
// Start/8-data/stop serial receiver with a valid/ready byte output and
// framing / overrun error pulses.
module serial_byte_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 SerialIn,
    output logic [DATA_BITS-1:0] Data_OUT,
    output logic                 DataValid,
    input  logic                 DataReady,
    output logic                 FrameError,
    output logic                 Overrun
);

    import serial_pkg::*;

    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam logic [2:0]     LAST_BIT  = 3'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state_r, state_nxt_s;
    logic [CW-1:0]        cnt_r, cnt_nxt_s;
    logic [2:0]           bit_idx_r, bit_idx_nxt_s;
    logic [DATA_BITS-1:0] sr_r, sr_nxt_s;
    logic                 done_r, done_nxt_s;
    logic                 ferr_r, ferr_nxt_s;
    logic [DATA_BITS-1:0] data_out_r;
    logic                 data_valid_r;
    logic                 frame_error_r;
    logic                 overrun_r;

    sync_2ff #(
        .RESET_VAL (IDLE_LEVEL)
    ) u_rx_sync (
        .clock (clock),
        .reset (reset),
        .d     (SerialIn),
        .q     (rx_s)
    );

    // Next-state logic: bit timing, sampling and end-of-frame decisions
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        bit_idx_nxt_s = bit_idx_r;
        sr_nxt_s      = sr_r;
        done_nxt_s    = 1'b0;
        ferr_nxt_s    = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_nxt_s = '0;
                if (rx_s == 1'b0) begin
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_nxt_s = '0;
                    if (rx_s == 1'b0) begin
                        state_nxt_s = DATA;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_r == FULL_LAST) begin
                    cnt_nxt_s = '0;
                    sr_nxt_s  = {rx_s, sr_r[DATA_BITS-1:1]};
                    if (bit_idx_r == LAST_BIT) begin
                        bit_idx_nxt_s = 3'd0;
                        state_nxt_s   = STOP;
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            STOP: begin
                if (cnt_r == FULL_LAST) begin
                    cnt_nxt_s = '0;
                    if (rx_s == 1'b1) begin
                        done_nxt_s  = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        ferr_nxt_s  = 1'b1;
                        state_nxt_s = BREAK;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            BREAK: begin
                // A held-low line must rise before another start bit can be seen
                if (rx_s == 1'b1) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BREAK;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Receiver state, counters and shift register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            bit_idx_r <= 3'd0;
            sr_r      <= '0;
            done_r    <= 1'b0;
            ferr_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            sr_r      <= sr_nxt_s;
            done_r    <= done_nxt_s;
            ferr_r    <= ferr_nxt_s;
        end
    end

    // Output register: delivery, overrun and consume handshake
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_out_r    <= '0;
            data_valid_r  <= 1'b0;
            frame_error_r <= 1'b0;
            overrun_r     <= 1'b0;
        end else begin
            frame_error_r <= ferr_r;
            overrun_r     <= 1'b0;
            if (done_r) begin
                // A consumer taking the old byte this cycle frees the slot for the new one
                if (!data_valid_r || DataReady) begin
                    data_out_r   <= sr_r;
                    data_valid_r <= 1'b1;
                end else begin
                    overrun_r <= 1'b1;
                end
            end else if (data_valid_r && DataReady) begin
                data_valid_r <= 1'b0;
            end
        end
    end

    assign Data_OUT   = data_out_r;
    assign DataValid  = data_valid_r;
    assign FrameError = frame_error_r;
    assign Overrun    = overrun_r;

endmodule

// File: tb/tb_serial_byte_rx.sv
// Self-checking bench for serial_byte_rx: directed scenarios plus random frames
// compared every cycle against an event-scheduled behavioural model.
module tb_serial_byte_rx;

    localparam int C   = 4;
    // SerialIn driven just after edge n: 2 sync flops + 1 idle detect, half bit,
    // 9 full bits, then one clock for the delivery register.
    localparam int LAT = 3 + C / 2 + 9 * C + 1;

    logic       clock     = 1'b0;
    logic       reset     = 1'b1;
    logic       SerialIn  = 1'b1;
    logic       DataReady = 1'b1;
    logic [7:0] Data_OUT;
    logic       DataValid;
    logic       FrameError;
    logic       Overrun;

    serial_byte_rx #(
        .CLKS_PER_BIT (C),
        .DATA_BITS    (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .SerialIn   (SerialIn),
        .Data_OUT   (Data_OUT),
        .DataValid  (DataValid),
        .DataReady  (DataReady),
        .FrameError (FrameError),
        .Overrun    (Overrun)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int nprint   = 0;
    int cyc      = 0;

    // Pending frame outcomes: edge at which they surface, payload, stop-bit level
    int         ev_edge[$];
    logic [7:0] ev_data[$];
    logic       ev_good[$];

    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic       m_fe    = 1'b0;
    logic       m_ov    = 1'b0;
    logic       m_rdy;
    logic       m_deliver;
    logic [7:0] m_byte;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (nprint < 40) begin
                $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
                nprint++;
            end
        end
    endtask

    // Behavioural model: applies scheduled frame outcomes and the handshake rules per edge
    always @(posedge clock) begin
        cyc++;
        m_rdy     = DataReady;
        m_fe      = 1'b0;
        m_ov      = 1'b0;
        m_deliver = 1'b0;
        m_byte    = 8'h00;
        if (reset) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            ev_edge.delete();
            ev_data.delete();
            ev_good.delete();
        end else begin
            if (ev_edge.size() > 0 && ev_edge[0] == cyc) begin
                m_byte = ev_data[0];
                if (ev_good[0]) m_deliver = 1'b1;
                else            m_fe      = 1'b1;
                void'(ev_edge.pop_front());
                void'(ev_data.pop_front());
                void'(ev_good.pop_front());
            end
            if (m_deliver) begin
                if (!m_valid || m_rdy) begin
                    m_data  = m_byte;
                    m_valid = 1'b1;
                end else begin
                    m_ov = 1'b1;
                end
            end else if (m_valid && m_rdy) begin
                m_valid = 1'b0;
            end
        end
    end

    logic prev_valid = 1'b0;
    int   rise_cyc   = -1;
    int   n_rise     = 0;
    int   n_fe       = 0;
    int   n_ov       = 0;

    // Compare process: DUT outputs against the model on every falling edge
    always @(negedge clock) begin
        if (reset) begin
            check("rst_valid", {31'd0, DataValid}, 32'd0);
            check("rst_data", {24'd0, Data_OUT}, 32'd0);
            check("rst_ferr", {31'd0, FrameError}, 32'd0);
            check("rst_ovr", {31'd0, Overrun}, 32'd0);
        end else begin
            check("valid", {31'd0, DataValid}, {31'd0, m_valid});
            check("data", {24'd0, Data_OUT}, {24'd0, m_data});
            check("frame_error", {31'd0, FrameError}, {31'd0, m_fe});
            check("overrun", {31'd0, Overrun}, {31'd0, m_ov});
        end
        if (DataValid === 1'b1 && prev_valid !== 1'b1) begin
            rise_cyc = cyc;
            n_rise++;
        end
        if (FrameError === 1'b1) n_fe++;
        if (Overrun === 1'b1)    n_ov++;
        prev_valid = DataValid;
    end

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Must be called at posedge+1; leaves the line at the stop-bit level
    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        logic [9:0] bits;
        bits = {stop_v, b, 1'b0};
        ev_edge.push_back(cyc + LAT);
        ev_data.push_back(b);
        ev_good.push_back(stop_v);
        for (int i = 0; i < 10; i++) begin
            SerialIn = bits[i];
            idle(C);
        end
    endtask

    int         s0, r0, f0, o0;
    logic [9:0] pbits;
    logic [7:0] rb;
    logic       rgood;
    int         rgap;
    logic       rnd_done = 1'b0;

    initial begin
        idle(3);
        check("reset_valid_lit", {31'd0, DataValid}, 32'd0);
        check("reset_data_lit", {24'd0, Data_OUT}, 32'h00);
        reset = 1'b0;
        idle(5);

        // 1: single frame 0xA5, consumer ready
        s0 = cyc; f0 = n_fe; o0 = n_ov;
        send_frame(8'hA5, 1'b1);
        idle(2);
        check("t1_data", {24'd0, Data_OUT}, 32'hA5);
        check("t1_valid", {31'd0, DataValid}, 32'd1);
        idle(1);
        check("t1_valid_one_clk", {31'd0, DataValid}, 32'd0);
        check("t1_latency", rise_cyc - s0, 32'd42);
        check("t1_no_err", n_fe - f0 + n_ov - o0, 32'd0);
        idle(5);

        // 2: back-to-back 0x3C, 0xFF with no consumer
        DataReady = 1'b0; o0 = n_ov;
        send_frame(8'h3C, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(4);
        check("t2_data", {24'd0, Data_OUT}, 32'h3C);
        check("t2_valid", {31'd0, DataValid}, 32'd1);
        check("t2_overrun_cnt", n_ov - o0, 32'd1);
        DataReady = 1'b1;
        idle(2);
        check("t2_consumed", {31'd0, DataValid}, 32'd0);
        idle(3);

        // 3: bad stop bit, line held low afterwards
        f0 = n_fe; r0 = n_rise;
        send_frame(8'h55, 1'b0);
        idle(20);
        check("t3_ferr_cnt", n_fe - f0, 32'd1);
        check("t3_no_delivery", n_rise - r0, 32'd0);
        check("t3_valid", {31'd0, DataValid}, 32'd0);
        SerialIn = 1'b1;
        idle(6);

        // 4: one-clock glitch, then a real frame
        r0 = n_rise; f0 = n_fe;
        SerialIn = 1'b0;
        idle(1);
        SerialIn = 1'b1;
        idle(C / 2 + 4);
        check("t4_no_output", n_rise - r0 + n_fe - f0, 32'd0);
        send_frame(8'hC3, 1'b1);
        idle(3);
        check("t4_after_glitch", {24'd0, Data_OUT}, 32'hC3);
        check("t4_one_delivery", n_rise - r0, 32'd1);
        idle(3);

        // 5: reset during data bit 4 of 0x81, then 0x42
        r0 = n_rise; f0 = n_fe;
        ev_edge.push_back(cyc + LAT);
        ev_data.push_back(8'h81);
        ev_good.push_back(1'b1);
        pbits = {1'b1, 8'h81, 1'b0};
        for (int i = 0; i < 5; i++) begin
            SerialIn = pbits[i];
            idle(C);
        end
        SerialIn = pbits[5];
        idle(2);
        reset = 1'b1;
        SerialIn = 1'b1;
        #2;
        check("t5_rst_valid", {31'd0, DataValid}, 32'd0);
        check("t5_rst_data", {24'd0, Data_OUT}, 32'h00);
        idle(3);
        reset = 1'b0;
        idle(3);
        send_frame(8'h42, 1'b1);
        idle(3);
        check("t5_data", {24'd0, Data_OUT}, 32'h42);
        check("t5_only_one", n_rise - r0, 32'd1);
        check("t5_no_ferr", n_fe - f0, 32'd0);
        idle(3);

        // 6: consumer takes 0x11 on the very edge 0x99 is delivered
        DataReady = 1'b0; o0 = n_ov;
        send_frame(8'h11, 1'b1);
        idle(3);
        check("t6_first", {24'd0, Data_OUT}, 32'h11);
        fork
            send_frame(8'h99, 1'b1);
            begin
                idle(LAT - 1);
                DataReady = 1'b1;
            end
        join
        idle(1);
        check("t6_data", {24'd0, Data_OUT}, 32'h99);
        check("t6_valid", {31'd0, DataValid}, 32'd1);
        idle(2);
        check("t6_no_overrun", n_ov - o0, 32'd0);
        idle(3);

        // Random frames, occasional bad stop bits, random consumer
        fork
            begin
                for (int k = 0; k < 30; k++) begin
                    rb    = 8'($urandom);
                    rgood = ($urandom_range(0, 9) != 0);
                    send_frame(rb, rgood);
                    SerialIn = 1'b1;
                    rgap = rgood ? $urandom_range(0, 5) : $urandom_range(1, 5);
                    idle(rgap);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clock);
                    #1;
                    DataReady = 1'($urandom_range(0, 1));
                end
            end
        join
        DataReady = 1'b1;
        idle(LAT + 10);
        check("drain_events", ev_edge.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
